// File: rtl/nv_ram_pkg.sv
// Shared definitions for the parametrised rwsp RAM: power states,
// wake-counter width and the parity helper.
package nv_ram_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } pwr_state_e;

  localparam int WAKE_CNT_W = 8;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 1024;

  // Even parity: returns the bit that makes the total number of ones even.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/nv_ram_pwr_fsm.sv
// Power-down / wake sequencer for the rwsp RAM. ram_ready is a registered
// copy of "state is ACTIVE", so there is no combinational path from pd.
module nv_ram_pwr_fsm
  import nv_ram_pkg::*;
#(
  parameter int WAKE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pd,
  output logic ram_ready
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD =
    (WAKE_CYCLES > 0) ? WAKE_CNT_W'(WAKE_CYCLES - 1) : '0;

  pwr_state_e             state_q;
  logic [WAKE_CNT_W-1:0]  cnt_q;
  logic                   ready_q;

  // State, wake counter and ready flag advance together; pd in WAKE beats counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (pd) begin
            state_q <= SLEEP;
            ready_q <= 1'b0;
          end
        end
        SLEEP: begin
          if (!pd) begin
            if (WAKE_CYCLES == 0) begin
              state_q <= ACTIVE;
              ready_q <= 1'b1;
            end else begin
              state_q <= WAKE;
              cnt_q   <= WAKE_LOAD;
            end
          end
        end
        WAKE: begin
          if (pd) begin
            state_q <= SLEEP;
          end else if (cnt_q == '0) begin
            state_q <= ACTIVE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ACTIVE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ram_ready = ready_q;

endmodule

// File: rtl/nv_ram_rwsp_param.sv
// Parametrised one-write/one-read RAM with registered read address,
// output-enable data register, write-to-read bypass, out-of-range protection
// and power-down sequencing. Optional per-word parity: NV_RAM_PARITY_EN.
module nv_ram_rwsp_param
  import nv_ram_pkg::*;
#(
  parameter int DW          = 65,
  parameter int DEPTH       = 160,
  parameter int AW          = $clog2(DEPTH),
  parameter int WAKE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic          ram_ready,
  output logic          rd_collision,
  input  logic          pinj,
  output logic          parity_err
);

`ifdef NV_RAM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic          act;
  logic          we_act;
  logic          re_act;
  logic          ore_act;
  logic          wr_in_rng;
  logic          rd_in_rng;
  logic          bypass;
  logic [MW-1:0] wdata;
  logic [MW-1:0] rdata;

  logic [MW-1:0] mem_q [DEPTH];
  logic [AW-1:0] ra_d_q;
  logic [DW-1:0] dout_q;
  logic          coll_q;

  nv_ram_pwr_fsm #(
    .WAKE_CYCLES (WAKE_CYCLES)
  ) u_pwr (
    .clk       (clk),
    .rst       (rst),
    .pd        (|pwrbus_ram_pd),
    .ram_ready (act)
  );

  assign ram_ready = act;
  assign we_act    = we  & act;
  assign re_act    = re  & act;
  assign ore_act   = ore & act;
  assign wr_in_rng = {1'b0, wa} < DEPTH_C;
  assign rd_in_rng = {1'b0, ra_d_q} < DEPTH_C;
  assign bypass    = we_act && (wa == ra_d_q);

`ifdef NV_RAM_PARITY_EN
  assign wdata = {even_par(PAR_MAX_W'(di)) ^ pinj, di};
`else
  logic unused_pinj;
  assign unused_pinj = pinj;
  assign wdata = di;
`endif

  // Read-data select: same-cycle write wins, then out-of-range zero, then array.
  always_comb begin
    rdata = '0;
    if (bypass) begin
      rdata = wdata;
    end else if (rd_in_rng) begin
      rdata = mem_q[ra_d_q];
    end
  end

  // Array write; out-of-range addresses are dropped, contents are never reset.
  always_ff @(posedge clk) begin
    if (we_act && wr_in_rng) begin
      mem_q[wa] <= wdata;
    end
  end

  // Read-address capture, output register and collision flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_d_q <= '0;
      dout_q <= '0;
      coll_q <= 1'b0;
    end else begin
      if (re_act) begin
        ra_d_q <= ra;
      end
      if (ore_act) begin
        dout_q <= rdata[DW-1:0];
      end
      coll_q <= re_act & we_act & (ra == wa);
    end
  end

  assign dout         = dout_q;
  assign rd_collision = coll_q;

`ifdef NV_RAM_PARITY_EN
  logic perr_q;

  // Parity is re-checked on every output capture and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if (ore_act) begin
      perr_q <= even_par(PAR_MAX_W'(rdata[DW-1:0])) != rdata[DW];
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Directed bench for nv_ram_rwsp_param (DW=65, DEPTH=160, WAKE_CYCLES=4).
module tb_nv_ram_rwsp_param;

  localparam int DW    = 65;
  localparam int DEPTH = 160;
  localparam int AW    = 8;

`ifdef NV_RAM_PARITY_EN
  localparam logic PAR_INJ_EXP = 1'b1;
`else
  localparam logic PAR_INJ_EXP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [AW-1:0] ra;
  logic          re;
  logic          ore;
  logic [DW-1:0] dout;
  logic [AW-1:0] wa;
  logic          we;
  logic [DW-1:0] di;
  logic [31:0]   pwrbus_ram_pd;
  logic          ram_ready;
  logic          rd_collision;
  logic          pinj;
  logic          parity_err;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] data5;
  int            n_chk;
  int            n_err;

  nv_ram_rwsp_param #(
    .DW          (DW),
    .DEPTH       (DEPTH),
    .WAKE_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ra            (ra),
    .re            (re),
    .ore           (ore),
    .dout          (dout),
    .wa            (wa),
    .we            (we),
    .di            (di),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .ram_ready     (ram_ready),
    .rd_collision  (rd_collision),
    .pinj          (pinj),
    .parity_err    (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wa = a; di = d;
    step();
    we = 1'b0;
    if (int'(a) < DEPTH) model[a] = d;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    re = 1'b1; ra = a;
    step();
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
  endtask

  task automatic wake_count(input string tag);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_val($sformatf("%s_%0d", tag, i), DW'(ram_ready), DW'(i == 5));
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; ra = '0; re = 1'b0; ore = 1'b0; wa = '0; we = 1'b0;
    di = '0; pwrbus_ram_pd = '0; pinj = 1'b0;
    step();
    check_val("rst_ready", DW'(ram_ready), 65'h1);
    check_val("rst_dout", dout, 65'h0);
    check_val("rst_coll", DW'(rd_collision), 65'h0);
    check_val("rst_perr", DW'(parity_err), 65'h0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      wr(AW'(i), {1'b1, 32'(i * 3 + 7), 32'hC0DE_0000 | 32'(i)});

    // Write/read with two-cycle latency
    wr(8'd4, 65'h4444);
    data5 = 65'h1_DEAD_BEEF_0123_4567;
    wr(8'd5, data5);
    re = 1'b1; ra = 8'd5;
    step();
    check_val("lat_not_yet", dout, 65'h0);
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    check_val("rd_addr5", dout, data5);
    rd(8'd4);
    check_val("rd_addr4", dout, 65'h4444);

    // Bypass
    wr(8'd7, 65'hA);
    re = 1'b1; ra = 8'd7;
    step();
    re = 1'b0; ore = 1'b1; we = 1'b1; wa = 8'd7; di = 65'hB;
    step();
    model[7] = 65'hB;
    we = 1'b0;
    check_val("bypass", dout, 65'hB);
    step();
    ore = 1'b0;
    check_val("bypass_after", dout, 65'hB);

    // Collision
    re = 1'b1; we = 1'b1; ra = 8'd3; wa = 8'd3; di = 65'h33;
    step();
    model[3] = 65'h33;
    check_val("coll_set", DW'(rd_collision), 65'h1);
    re = 1'b0; we = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    check_val("coll_clr", DW'(rd_collision), 65'h0);
    check_val("coll_data", dout, 65'h33);
    re = 1'b1; we = 1'b1; ra = 8'd2; wa = 8'd3; di = 65'h34;
    step();
    model[3] = 65'h34;
    re = 1'b0; we = 1'b0;
    check_val("coll_diff_addr", DW'(rd_collision), 65'h0);

    // Out-of-range write and read, last valid address
    wr(8'd200, 65'hBAD);
    wr(8'd159, 65'h159);
    rd(8'd40);
    check_val("oor_wr_40", dout, model[40]);
    rd(8'd159);
    check_val("rd_last", dout, 65'h159);
    rd(8'd200);
    check_val("oor_rd_200", dout, 65'h0);
    rd(8'd5);
    rd(8'd170);
    check_val("oor_rd_170", dout, 65'h0);

    // Power-down: write in the pd cycle still executes, then everything holds
    rd(8'd5);
    pwrbus_ram_pd = 32'h0000_0100;
    we = 1'b1; wa = 8'd6; di = 65'h6666;
    step();
    model[6] = 65'h6666;
    check_val("pd_ready", DW'(ram_ready), 65'h0);
    we = 1'b1; wa = 8'd5; di = 65'h999; re = 1'b1; ra = 8'd4; ore = 1'b1;
    step();
    check_val("sleep_dout", dout, data5);
    step();
    check_val("sleep_ready", DW'(ram_ready), 65'h0);
    we = 1'b0; re = 1'b0; ore = 1'b0;
    pwrbus_ram_pd = '0;
    wake_count("wake");
    ore = 1'b1;
    step();
    ore = 1'b0;
    check_val("sleep_ops_ignored", dout, data5);
    rd(8'd6);
    check_val("pd_cycle_write", dout, 65'h6666);

    // Re-assert pd during WAKE
    pwrbus_ram_pd = 32'h1;
    step();
    pwrbus_ram_pd = '0;
    step();
    step();
    pwrbus_ram_pd = 32'h8000_0000;
    step();
    check_val("wake_abort", DW'(ram_ready), 65'h0);
    pwrbus_ram_pd = '0;
    wake_count("rewake");

    // Retention
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i));
      check_val($sformatf("keep_%0d", i), dout, model[i]);
    end

    // Reset mid-WAKE with cnt=2
    pwrbus_ram_pd = 32'h1;
    step();
    pwrbus_ram_pd = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rstw_ready", DW'(ram_ready), 65'h1);
    check_val("rstw_dout", dout, 65'h0);
    check_val("rstw_coll", DW'(rd_collision), 65'h0);

    // Reset mid-WAKE with pd still high
    pwrbus_ram_pd = 32'h1;
    step();
    pwrbus_ram_pd = '0;
    step();
    pwrbus_ram_pd = 32'h1; rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rstpd_ready", DW'(ram_ready), 65'h1);
    step();
    check_val("rstpd_sleep", DW'(ram_ready), 65'h0);
    pwrbus_ram_pd = '0;
    wake_count("rstpd_wake");

    // Parity
    pinj = 1'b1;
    wr(8'd9, 65'h1234);
    pinj = 1'b0;
    rd(8'd9);
    check_val("par_data", dout, 65'h1234);
    check_val("par_inj", DW'(parity_err), DW'(PAR_INJ_EXP));
    wr(8'd9, 65'h1234);
    rd(8'd9);
    check_val("par_clean", DW'(parity_err), 65'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/nv_ram_rwsp_param.md
Name: nv_ram_rwsp_param

Overview:
- Parametrised successor to the fixed-geometry two-port FPGA RAM models: one write port, one read port, registered read address and output-enable data register.
- Adds same-cycle write-to-read bypass and out-of-range address protection.
- Adds a power-down/wake state machine driven by pwrbus_ram_pd.
- Drop-in replacement for per-size rwsp FPGA RAMs inside NVDLA sub-units.

Parameters:
- DW, 65: data width in bits.
- DEPTH, 160: number of words.
- AW, $clog2(DEPTH): address width (derived; not overridden).
- WAKE_CYCLES, 4: cycles spent in WAKE before ACTIVE; legal range 0..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ra  in  AW  read address.
- re  in  1  read-address capture enable.
- ore  in  1  output-register enable.
- dout  out  DW  registered read data.
- wa  in  AW  write address.
- we  in  1  write enable.
- di  in  DW  write data.
- pwrbus_ram_pd  in  32  power-down request; any bit set means power down.
- ram_ready  out  1  high only in the ACTIVE state.
- rd_collision  out  1  one-cycle pulse flagging a same-address read/write.
- pinj  in  1  parity-error injection; used only with the optional feature.
- parity_err  out  1  registered parity error.

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to ACTIVE; ra_d, dout_r and the wake counter clear to 0.
  - rd_collision = 0 and parity_err = 0.
  - Memory contents are not reset.
- Gating: "act" = state is ACTIVE. Effective signals are we&act, re&act and ore&act. When not act, dout, ra_d and memory hold.
- Write: when we&act and wa < DEPTH, M[wa] <= di. When wa >= DEPTH the write is dropped and no location changes.
- Read address: when re&act, ra_d <= ra.
- Output: when ore&act, dout_r <= rdata, where rdata is selected in this priority:
  - di, if we&act and wa==ra_d (bypass: the newest data wins);
  - otherwise 0, if ra_d >= DEPTH;
  - otherwise M[ra_d].
- Latency: re at cycle N and ore at cycle N+1 give data on dout in cycle N+2. If ore is held, dout updates every cycle from the current ra_d.
- rd_collision is registered: it is set in cycle N+1 iff re&act and we&act and ra==wa in cycle N. It is informational only; the data read is the newly written word.
- Power FSM, with pd = |pwrbus_ram_pd:
  - ACTIVE -> SLEEP when pd.
  - SLEEP -> WAKE when !pd, loading cnt = WAKE_CYCLES-1. If WAKE_CYCLES==0, SLEEP goes directly to ACTIVE.
  - WAKE -> SLEEP when pd (this has priority over counting).
  - WAKE -> ACTIVE when cnt==0; otherwise cnt decrements.
  - ram_ready = (state==ACTIVE), driven from the state register with no combinational path from pd.
  - Contents are retained across SLEEP (retention model).
- pd asserting in the same cycle as we, re or ore: the operation executes, because the state is still ACTIVE during that cycle.
- rst asserted mid-WAKE: returns to ACTIVE at the next edge. If pd is still high, the FSM enters SLEEP one cycle later.

Optional Feature:
- Macro: NV_RAM_PARITY_EN.
- With the macro defined:
  - Storage is DW+1 bits per word; the stored parity bit is ^di ^ pinj.
  - Bypass data carries the parity bit ^di ^ pinj.
  - On each ore&act capture, parity_err <= (recomputed ^data != stored parity). It holds otherwise.
  - Out-of-range reads return zero data with parity 0 and raise no error.
- Without the macro: storage is DW bits, parity_err is constant 0 and pinj is ignored.

Decomposition:
- Package nv_ram_pkg holds:
  - the power-state enum (ACTIVE=2'd0, SLEEP=2'd1, WAKE=2'd2);
  - the wake-counter width constant (8);
  - an even-parity function.
- Sub-module nv_ram_pwr_fsm: inputs clk, rst, pd; output ram_ready; parameter WAKE_CYCLES.
- The array, bypass and output register stay in the top module.

Test Plan:
- Write/read: write 0x1_DEAD_BEEF_0123_4567 to address 5. Then re with ra=5, then ore. -> dout equals the written data two cycles after re; the word at address 4 is unchanged.
- Bypass: ra_d=7 holding 0xA. In one cycle assert ore with we, wa=7, di=0xB. -> dout=0xB next cycle. A following ore with no write -> 0xB.
- Collision/out-of-range:
  - re and we with ra=wa=3 -> rd_collision high for exactly 1 cycle.
  - we with wa=200 (DEPTH=160) -> no write occurs.
  - ra=170 followed by ore -> dout=0.
- Power:
  - pwrbus_ram_pd=32'h0000_0100 while ACTIVE -> ram_ready=0 next cycle; we, re and ore are ignored and dout holds.
  - Deassert pd -> ram_ready returns after exactly 1+WAKE_CYCLES (=5) cycles.
  - Re-assert pd during WAKE -> back to SLEEP.
  - Contents at addresses 0..159 are intact afterwards.
- Reset mid-WAKE: rst for 1 cycle while in WAKE with cnt=2 -> ram_ready=1, dout=0 and rd_collision=0 on the next cycle.
- Parity (NV_RAM_PARITY_EN): write address 9 with pinj=1, read it back -> parity_err=1. Rewrite with pinj=0, read -> parity_err=0. Without the macro, parity_err stays 0 throughout.
